// File: rtl/dcache_pkg.sv
// dcache_pkg: controller state encoding, index/tag geometry helpers and the store byte-merge.
// Shared by the dcache controller and its line array.
package dcache_pkg;

  localparam int WORD_W    = 32;
  localparam int WORD_BE_W = WORD_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_BUS_RD,
    S_BUS_WR,
    S_RESP
  } state_e;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  // Two address bits select the byte within the word and never reach the tag.
  function automatic int tag_width(input int data_width, input int lines);
    return data_width - $clog2(lines) - 2;
  endfunction

  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0]    word,
                                                   input logic [WORD_W-1:0]    new_word,
                                                   input logic [WORD_BE_W-1:0] be);
    logic [WORD_W-1:0] merged;
    merged = word;
    for (int b = 0; b < WORD_BE_W; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: per-line valid/tag/data with combinational read and one clocked write port.
// Fills drive wr_be all ones; store hits drive the LSU lanes. Valid bits clear asynchronously on reset.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W,
  parameter int LINES      = 16,
  parameter int IDX_W      = idx_width(LINES),
  parameter int TAG_W      = tag_width(DATA_WIDTH, LINES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_vld,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [DATA_WIDTH-1:0]   rd_dat,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [DATA_WIDTH-1:0]   wr_dat,
  input  logic [DATA_WIDTH/8-1:0] wr_be
);

  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [TAG_W-1:0]      tag_d  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];
  logic [DATA_WIDTH-1:0] data_d [LINES];

  assign rd_vld = valid_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_dat = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = byte_merge(data_q[wr_idx], wr_dat, wr_be);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Tag and data contents are only meaningful behind a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-through no-write-allocate cache; load hit data_valid 2 cycles after accept, miss/store 3+N.
// Single request in flight, bus_req held until bus_ack; `define DCACHE_STATS_EN adds hit_count/miss_count.
module dcache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int LINES           = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_req,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       inst_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       bus_req,
  output logic                       bus_we,
  output logic [DATA_WIDTH-1:0]      bus_addr,
  output logic [DATA_WIDTH-1:0]      bus_wdata,
  output logic [BYTE_DATA_WIDTH-1:0] bus_be,
  input  logic                       bus_ack,
  input  logic [DATA_WIDTH-1:0]      bus_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
`endif
);

  localparam int IDX_W = idx_width(LINES);
  localparam int TAG_W = tag_width(DATA_WIDTH, LINES);

  typedef struct packed {
    logic [DATA_WIDTH-3:0]      waddr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       we;
    logic [BYTE_DATA_WIDTH-1:0] be;
  } req_t;

  state_e                     state_q, state_d;
  req_t                       req_q, req_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       data_valid_q, data_valid_d;
  logic                       bus_req_q, bus_req_d;
  logic                       bus_we_q, bus_we_d;
  logic [DATA_WIDTH-1:0]      bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]      bus_wdata_q, bus_wdata_d;
  logic [BYTE_DATA_WIDTH-1:0] bus_be_q, bus_be_d;

  logic [IDX_W-1:0]           req_idx;
  logic [TAG_W-1:0]           req_tag;
  logic                       line_vld, hit;
  logic [TAG_W-1:0]           line_tag;
  logic [DATA_WIDTH-1:0]      line_dat;
  logic                       wr_en;
  logic [DATA_WIDTH-1:0]      wr_dat;
  logic [BYTE_DATA_WIDTH-1:0] wr_be;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^data_addr[1:0];
  assign req_idx = req_q.waddr[IDX_W-1:0];
  assign req_tag = req_q.waddr[DATA_WIDTH-3:IDX_W];
  assign hit     = line_vld && (line_tag == req_tag);

  dcache_line_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINES      (LINES),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (req_idx),
    .rd_vld (line_vld),
    .rd_tag (line_tag),
    .rd_dat (line_dat),
    .wr_en  (wr_en),
    .wr_idx (req_idx),
    .wr_tag (req_tag),
    .wr_dat (wr_dat),
    .wr_be  (wr_be)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    data_valid_d = 1'b0;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    wr_en        = 1'b0;
    wr_dat       = bus_rdata;
    wr_be        = '1;
    unique case (state_q)
      S_IDLE: begin
        if (data_req) begin
          req_d.waddr = data_addr[DATA_WIDTH-1:2];
          req_d.wdata = wdata;
          req_d.we    = inst_we;
          req_d.be    = byte_enable;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (req_q.we) begin
          // Write-through: every store reaches the bus; a hit also updates the line in place.
          wr_en       = hit;
          wr_dat      = req_q.wdata;
          wr_be       = req_q.be;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = {req_q.waddr, 2'b00};
          bus_wdata_d = req_q.wdata;
          bus_be_d    = req_q.be;
          state_d     = S_BUS_WR;
        end else if (hit) begin
          rdata_d      = line_dat;
          data_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = {req_q.waddr, 2'b00};
          bus_be_d   = '1;
          state_d    = S_BUS_RD;
        end
      end
      S_BUS_RD: begin
        if (bus_ack) begin
          wr_en        = 1'b1;
          rdata_d      = bus_rdata;
          bus_req_d    = 1'b0;
          data_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_BUS_WR: begin
        if (bus_ack) begin
          bus_req_d    = 1'b0;
          data_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      rdata_q      <= '0;
      data_valid_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      data_valid_q <= data_valid_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
    end
  end

  assign data_valid = data_valid_q;
  assign rdata      = rdata_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Only loads are classified; the counters wrap naturally at 2^32.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP && !req_q.we) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
